// File: rtl/reg_dump_reader.sv
// Purpose : debug read-side master that walks an address range through one
//           register-file read port and streams (address, data) pairs out.
// Latency : Start accepted -> first DumpValid after 2 posedges; 2 cycles/word minimum.
// Backpressure: a presented word is held in HOLD until DumpValid && DumpReady;
//               Abort cancels at any time and takes priority over a handshake.
//
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Start, Abort          begin a dump (IDLE only) / cancel an active dump
//   FirstAddr, LastAddr   inclusive address range, latched on accepted Start
//   RegRdAddr, RegRdData  register-file read port (data is combinational)
//   DumpValid, DumpReady  output word handshake
//   DumpAddr, DumpData    presented word and its address
//   Busy, Done            dump in progress / one-cycle completion pulse
//   WordCount, DumpSum    words transferred and their mod-2^DATA_W sum

module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] RegRdAddr,
  input  logic [DATA_W-1:0] RegRdData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [DATA_W-1:0] DumpData,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  WordCount,
  output logic [DATA_W-1:0] DumpSum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] rd_word;
  logic              at_last;

  // cur only changes on the way into READ, so it doubles as the read
  // address and naturally holds its last value outside READ.
  assign RegRdAddr = cur;

  // Address 0 reads as zero regardless of what the register file returns.
  assign rd_word = (cur == '0) ? '0 : RegRdData;
  assign at_last = (cur == last_addr);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        state_nxt = Abort ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        // Abort wins over a handshake in the same cycle.
        if (Abort) begin
          state_nxt = ST_IDLE;
        end else if (DumpReady) begin
          state_nxt = at_last ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    DumpValid = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      ST_READ: Busy = 1'b1;
      ST_HOLD: begin
        Busy      = 1'b1;
        DumpValid = 1'b1;
      end
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address walk, captured word, counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cur       <= '0;
      last_addr <= '0;
      DumpAddr  <= '0;
      DumpData  <= '0;
      WordCount <= '0;
      DumpSum   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            cur       <= FirstAddr;
            last_addr <= LastAddr;
            WordCount <= '0;
            DumpSum   <= '0;
          end
        end
        ST_READ: begin
          if (!Abort) begin
            DumpAddr  <= cur;
            DumpData  <= rd_word;
            DumpSum   <= DumpSum + rd_word;
            WordCount <= WordCount + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          // Increment wraps mod 2^ADDR_W, giving the FirstAddr > LastAddr walk.
          if (!Abort && DumpReady && !at_last) begin
            cur <= cur + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Purpose : directed self-checking bench for reg_dump_reader with a behavioural
//           32x32 register file (combinational read, bench-driven writes).
// Ports   : none; drives every DUT port, prints one summary line.

module tb_reg_dump_reader;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic        Abort;
  logic [4:0]  FirstAddr;
  logic [4:0]  LastAddr;
  logic [4:0]  RegRdAddr;
  logic [31:0] RegRdData;
  logic        DumpValid;
  logic        DumpReady;
  logic [4:0]  DumpAddr;
  logic [31:0] DumpData;
  logic        Busy;
  logic        Done;
  logic [5:0]  WordCount;
  logic [31:0] DumpSum;

  logic [31:0] rf [32];
  assign RegRdData = rf[RegRdAddr];

  reg_dump_reader #(.ADDR_W(5), .DATA_W(32), .CNT_W(6)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Abort     (Abort),
    .FirstAddr (FirstAddr),
    .LastAddr  (LastAddr),
    .RegRdAddr (RegRdAddr),
    .RegRdData (RegRdData),
    .DumpValid (DumpValid),
    .DumpReady (DumpReady),
    .DumpAddr  (DumpAddr),
    .DumpData  (DumpData),
    .Busy      (Busy),
    .Done      (Done),
    .WordCount (WordCount),
    .DumpSum   (DumpSum)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Words observed during a dump, with the cycle index (posedges after the
  // Start-accepting edge) at which each was seen valid.
  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  int          got_k    [$];
  logic [4:0]  exp_addr [$];
  logic [31:0] exp_data [$];
  int          done_k;

  task automatic do_dump(input logic [4:0] first, input logic [4:0] last);
    got_addr.delete();
    got_data.delete();
    got_k.delete();
    done_k    = -1;
    FirstAddr = first;
    LastAddr  = last;
    DumpReady = 1'b1;
    Start     = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge Clk); #1;
      if (DumpValid) begin
        got_addr.push_back(DumpAddr);
        got_data.push_back(DumpData);
        got_k.push_back(k);
      end
      if (Done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic cmp_words(input string tag);
    chk({tag, "_done_seen"}, 64'(done_k != -1), 64'(1));
    chk({tag, "_nwords"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    foreach (exp_addr[i]) begin
      if (i < got_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
        chk($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
      end
    end
  endtask

  // Done must be a single-cycle pulse followed by IDLE.
  task automatic post_done(input string tag);
    @(posedge Clk); #1;
    chk({tag, "_done_width"}, 64'(Done), 64'(0));
    chk({tag, "_idle_busy"},  64'(Busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        stable;
    logic [31:0] sum;
    int          first_k;

    Rst_n = 1'b0; Start = 1'b0; Abort = 1'b0;
    FirstAddr = '0; LastAddr = '0; DumpReady = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", 64'(DumpValid), 64'(0));
    chk("rst_busy",  64'(Busy),      64'(0));
    chk("rst_done",  64'(Done),      64'(0));
    chk("rst_rdaddr",64'(RegRdAddr), 64'(0));
    chk("rst_daddr", 64'(DumpAddr),  64'(0));
    chk("rst_ddata", 64'(DumpData),  64'(0));
    chk("rst_wcnt",  64'(WordCount), 64'(0));
    chk("rst_sum",   64'(DumpSum),   64'(0));
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // T1: regs 1..5 = 0x11..0x55, straight dump with DumpReady high
    for (int i = 1; i <= 5; i++) rf[i] = 32'(i) * 32'h11;
    do_dump(5'd1, 5'd5);
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    exp_data = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    cmp_words("t1");
    first_k = (got_k.size() > 0) ? got_k[0] : -1;
    chk("t1_first_latency", 64'(first_k), 64'(1));
    for (int i = 1; i < 5; i++) begin
      if (i < got_k.size()) chk($sformatf("t1_spacing%0d", i), 64'(got_k[i]), 64'(2 * i + 1));
    end
    chk("t1_done_cycle", 64'(done_k), 64'(10));
    chk("t1_wcnt", 64'(WordCount), 64'(5));
    chk("t1_sum",  64'(DumpSum),   64'(32'hFF));
    post_done("t1");
    chk("t1_wcnt_hold", 64'(WordCount), 64'(5));

    // T2: address 0 reads as zero even if the file holds something
    rf[0] = 32'hDEAD;
    do_dump(5'd0, 5'd0);
    exp_addr = '{5'd0};
    exp_data = '{32'h0};
    cmp_words("t2");
    chk("t2_wcnt", 64'(WordCount), 64'(1));
    chk("t2_sum",  64'(DumpSum),   64'(0));
    post_done("t2");

    // T3: wrap-around 30,31,0,1
    rf[30] = 32'd1; rf[31] = 32'd2; rf[0] = 32'h5A5A; rf[1] = 32'd3;
    do_dump(5'd30, 5'd1);
    exp_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
    exp_data = '{32'd1, 32'd2, 32'd0, 32'd3};
    cmp_words("t3");
    chk("t3_wcnt", 64'(WordCount), 64'(4));
    chk("t3_sum",  64'(DumpSum),   64'(6));
    post_done("t3");

    // Full 32-word dump, First=1, Last=0
    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * 32'(i) + 32'h00F0_0000;
    exp_addr.delete();
    exp_data.delete();
    sum = '0;
    for (int j = 0; j < 32; j++) begin
      logic [4:0] a;
      a = 5'((1 + j) % 32);
      exp_addr.push_back(a);
      exp_data.push_back((a == 5'd0) ? 32'h0 : rf[a]);
      sum = sum + ((a == 5'd0) ? 32'h0 : rf[a]);
    end
    do_dump(5'd1, 5'd0);
    cmp_words("full");
    chk("full_wcnt", 64'(WordCount), 64'(32));
    chk("full_sum",  64'(DumpSum),   64'(sum));
    post_done("full");

    // T4: backpressure on the second word, Start pulses ignored meanwhile
    for (int i = 1; i <= 3; i++) rf[i] = 32'(i) * 32'h11;
    FirstAddr = 5'd1; LastAddr = 5'd3; DumpReady = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("t4_w1_addr", 64'(DumpAddr), 64'(1));
    @(posedge Clk); #1;
    DumpReady = 1'b0;
    @(posedge Clk); #1;
    chk("t4_w2_valid", 64'(DumpValid), 64'(1));
    chk("t4_w2_data",  64'(DumpData),  64'(32'h22));
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Start = 1'b1;
      FirstAddr = 5'd9;
      @(posedge Clk); #1;
      stable = stable & DumpValid & Busy & (DumpAddr == 5'd2) & (DumpData == 32'h22);
    end
    chk("t4_stall_stable", 64'(stable), 64'(1));
    Start = 1'b0;
    DumpReady = 1'b1;
    @(posedge Clk); #1;
    chk("t4_resume_read", 64'(DumpValid), 64'(0));
    @(posedge Clk); #1;
    chk("t4_w3_addr", 64'(DumpAddr), 64'(3));
    chk("t4_w3_data", 64'(DumpData), 64'(32'h33));
    @(posedge Clk); #1;
    chk("t4_done",  64'(Done),      64'(1));
    chk("t4_wcnt",  64'(WordCount), 64'(3));
    chk("t4_sum",   64'(DumpSum),   64'(32'h66));
    post_done("t4");

    // T5: Abort in HOLD together with a handshake
    for (int i = 1; i <= 5; i++) rf[i] = 32'(i) * 32'h11;
    FirstAddr = 5'd1; LastAddr = 5'd5; DumpReady = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    chk("t5_w2_addr", 64'(DumpAddr), 64'(2));
    Abort = 1'b1;
    @(posedge Clk); #1;
    chk("t5_valid", 64'(DumpValid), 64'(0));
    chk("t5_busy",  64'(Busy),      64'(0));
    chk("t5_done",  64'(Done),      64'(0));
    chk("t5_wcnt",  64'(WordCount), 64'(2));
    chk("t5_sum",   64'(DumpSum),   64'(32'h33));
    chk("t5_rdaddr",64'(RegRdAddr), 64'(2));
    Abort = 1'b0;
    @(posedge Clk); #1;
    chk("t5_no_done_later", 64'(Done), 64'(0));

    // Abort in IDLE is ignored and Start is still accepted; a negedge write
    // during READ is captured with its new value.
    rf[4] = 32'h44;
    FirstAddr = 5'd4; LastAddr = 5'd4; Start = 1'b1; Abort = 1'b1;
    @(posedge Clk); #1;
    chk("t5b_accepted", 64'(Busy), 64'(1));
    Start = 1'b0; Abort = 1'b0;
    @(negedge Clk);
    rf[4] = 32'h4444;
    @(posedge Clk); #1;
    chk("t5b_valid", 64'(DumpValid), 64'(1));
    chk("t5b_data",  64'(DumpData),  64'(32'h4444));
    @(posedge Clk); #1;
    chk("t5b_done", 64'(Done),    64'(1));
    chk("t5b_sum",  64'(DumpSum), 64'(32'h4444));
    post_done("t5b");

    // T6: asynchronous reset mid-dump, then a clean dump
    FirstAddr = 5'd1; LastAddr = 5'd5; DumpReady = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("t6_pre_valid", 64'(DumpValid), 64'(1));
    #2;
    Rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(DumpValid), 64'(0));
    chk("t6_busy",  64'(Busy),      64'(0));
    chk("t6_daddr", 64'(DumpAddr),  64'(0));
    chk("t6_ddata", 64'(DumpData),  64'(0));
    chk("t6_wcnt",  64'(WordCount), 64'(0));
    chk("t6_sum",   64'(DumpSum),   64'(0));
    chk("t6_rdaddr",64'(RegRdAddr), 64'(0));
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    do_dump(5'd2, 5'd3);
    exp_addr = '{5'd2, 5'd3};
    exp_data = '{32'h22, 32'h33};
    cmp_words("t6");
    chk("t6_wcnt_after", 64'(WordCount), 64'(2));
    chk("t6_sum_after",  64'(DumpSum),   64'(32'h55));
    post_done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Debug read-side master for the 32x32 register file. On a Start pulse it walks a programmable address range through one register-file read port and streams each (address, data) pair out over a valid/ready interface. It also reports a running checksum. It sits between the register file's spare read port and the board debug/display path.

Parameters:
ADDR_W, 5, register-file address width
DATA_W, 32, register-file data width
CNT_W, 6, width of the word counter (must hold 2^ADDR_W)

Ports:
Clk  input  1  system clock; all state changes on posedge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  begin a dump; sampled only in IDLE
Abort  input  1  cancel an active dump
FirstAddr  input  ADDR_W  first address to read; latched on accepted Start
LastAddr  input  ADDR_W  last address to read; latched on accepted Start
RegRdAddr  output  ADDR_W  drives the register-file read address
RegRdData  input  DATA_W  combinational read data from the register file
DumpValid  output  1  DumpAddr/DumpData hold a word
DumpReady  input  1  downstream accepts the word
DumpAddr  output  ADDR_W  address of the presented word
DumpData  output  DATA_W  presented word
Busy  output  1  dump in progress (READ or HOLD)
Done  output  1  one-cycle pulse when a dump completes
WordCount  output  CNT_W  words transferred in the current or last dump
DumpSum  output  DATA_W  mod-2^DATA_W sum of words transferred

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE; RegRdAddr, DumpAddr, DumpData, WordCount, DumpSum = 0; DumpValid, Busy, Done = 0.
- States: IDLE, READ, HOLD, DONE.
- IDLE: if Start=1 at posedge, the block latches FirstAddr/LastAddr, sets cur=FirstAddr, clears WordCount and DumpSum, and goes to READ. Start in any other state is ignored.
- READ: RegRdAddr=cur, held stable for the whole cycle. At the next posedge:
  - DumpData <= (cur==0) ? 0 : RegRdData. Address 0 is forced to zero independent of the register file.
  - DumpAddr <= cur; DumpValid <= 1; DumpSum <= DumpSum + captured word; WordCount <= WordCount+1.
  - State goes to HOLD.
- HOLD: DumpValid=1. DumpAddr and DumpData are held stable until a handshake, which occurs when DumpValid&&DumpReady at a posedge.
  - On handshake with cur==LastAddr: DumpValid <= 0, go to DONE.
  - On handshake otherwise: DumpValid <= 0, cur <= cur+1 (mod 2^ADDR_W), go to READ.
- Throughput: 2 cycles per word minimum; latency from Start to first DumpValid is 2 posedges.
- DONE: Done=1 for exactly one cycle, then IDLE. WordCount and DumpSum hold until the next accepted Start.
- Busy=1 in READ and HOLD only.
- Wrap-around: if FirstAddr > LastAddr, the walk goes cur..31, then 0..LastAddr. FirstAddr==LastAddr produces exactly one word. A full 32-word dump (e.g. First=1, Last=0) gives WordCount=32.
- Abort=1 at a posedge in READ/HOLD/DONE: go to IDLE; DumpValid=0, Done not asserted. WordCount and DumpSum keep their partial values. Abort has priority over a simultaneous handshake. Abort in IDLE has no effect, and Start in the same cycle is still accepted.
- Register-file writes happen on negedge. The block samples on posedge, so a write to cur during READ is captured with its new value.
- RegRdAddr holds its last value outside READ.
- Rst_n asserted mid-dump returns to the reset state immediately.

Test Plan:
- Registers 1..5 preloaded 0x11..0x55; First=1, Last=5; DumpReady=1 -> five words 0x11..0x55 at addrs 1..5, one every 2 cycles; Done pulse; WordCount=5; DumpSum=0xFF.
- Register 0 written 0xDEAD (if the model allows) and First=Last=0 -> DumpData=0, WordCount=1, DumpSum=0.
- First=30, Last=1, regs 30,31,0,1 = 1,2,x,3 -> addrs 30,31,0,1 in order; data 1,2,0,3; DumpSum=6.
- DumpReady held low 10 cycles on the second word -> DumpValid stays 1 with DumpAddr/DumpData unchanged; Start pulses are ignored; the transfer resumes on release.
- Abort asserted in HOLD with DumpReady=1 in the same cycle -> next cycle IDLE, DumpValid=0, no Done, WordCount shows the partial count.
- Rst_n pulsed low asynchronously mid-dump -> all outputs 0 immediately; a new Start then completes normally.
